// File: rtl/audio_pkg.sv
// Types and frame constants shared by the DAC output path.
package audio_pkg;

   localparam int unsigned I2S_SLOTS_PER_FRAME = 64;
   localparam int unsigned I2S_DATA_BITS       = 16;

   typedef struct packed {
      logic signed [15:0] l;
      logic signed [15:0] r;
   } stereo_sample_t;

endpackage

// File: rtl/stereo_sample_fifo.sv
// Synchronous FIFO of stereo pairs; full/empty/level all derive from the registered level.
module stereo_sample_fifo
   import audio_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  stereo_sample_t           wdata_i,
   input  logic                     pop_i,
   output stereo_sample_t           rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   level_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned LvlW = PtrW + 1;

   stereo_sample_t  mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0] level_q, level_d;
   logic            do_push, do_pop;

   assign full_o  = (level_q == LvlW'(Depth));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // Depth is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + LvlW'(1);
         2'b01:   level_d = level_q - LvlW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/dac_i2s_serializer.sv
// Buffers stereo samples from the DSP and serializes them as a Philips I2S stream.
module dac_i2s_serializer
   import audio_pkg::*;
#(
   parameter int unsigned BCLK_DIV   = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic signed [15:0]            sample_l,
   input  logic signed [15:0]            sample_r,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          i2s_bclk,
   output logic                          i2s_lrclk,
   output logic                          i2s_sdata,
   output logic [7:0]                    underflow_count,
   output logic                          overflow
);

   localparam int unsigned DivW  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int unsigned SlotW = $clog2(I2S_SLOTS_PER_FRAME);

   localparam logic [DivW-1:0]  DivLast    = DivW'(BCLK_DIV - 1);
   localparam logic [SlotW-1:0] LeftFirst  = SlotW'(1);
   localparam logic [SlotW-1:0] LeftLast   = SlotW'(I2S_DATA_BITS);
   localparam logic [SlotW-1:0] RightFirst = SlotW'(I2S_SLOTS_PER_FRAME / 2 + 1);
   localparam logic [SlotW-1:0] RightLast  = SlotW'(I2S_SLOTS_PER_FRAME / 2 + I2S_DATA_BITS);
   localparam logic [SlotW-1:0] SlotLast   = SlotW'(I2S_SLOTS_PER_FRAME - 1);

   logic [DivW-1:0]  div_q, div_d;
   logic             bclk_q, bclk_d;
   logic [SlotW-1:0] slot_q, slot_d;
   logic             lrclk_q, lrclk_d;
   logic             sdata_q, sdata_d;
   logic [15:0]      sh_l_q, sh_l_d;
   logic [15:0]      sh_r_q, sh_r_d;
   logic [7:0]       underflow_q, underflow_d;
   logic             overflow_q, overflow_d;

   stereo_sample_t   fifo_wdata, fifo_rdata;
   logic             fifo_full, fifo_empty, fifo_pop;
   logic             div_tc, bclk_fall, frame_load;

   assign fifo_wdata = '{l: sample_l, r: sample_r};

   stereo_sample_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .push_i  (sample_valid),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign div_tc     = (div_q == DivLast);
   assign bclk_fall  = div_tc && bclk_q;
   assign frame_load = bclk_fall && (slot_q == SlotLast);
   assign fifo_pop   = frame_load && !fifo_empty;

   always_comb begin
      div_d       = div_tc ? '0 : div_q + DivW'(1);
      bclk_d      = div_tc ? ~bclk_q : bclk_q;
      slot_d      = slot_q;
      lrclk_d     = lrclk_q;
      sdata_d     = sdata_q;
      sh_l_d      = sh_l_q;
      sh_r_d      = sh_r_q;
      underflow_d = underflow_q;
      overflow_d  = overflow_q || (sample_valid && fifo_full);

      // Data changes on the falling BCLK so the DAC samples it stable on the rise.
      if (bclk_fall) begin
         slot_d  = slot_q + SlotW'(1);
         lrclk_d = slot_d[SlotW-1];
         sdata_d = 1'b0;
         if (frame_load) begin
            sh_l_d = fifo_empty ? 16'h0000 : fifo_rdata.l;
            sh_r_d = fifo_empty ? 16'h0000 : fifo_rdata.r;
            if (fifo_empty && underflow_q != 8'hFF) underflow_d = underflow_q + 8'd1;
         end else if (slot_d >= LeftFirst && slot_d <= LeftLast) begin
            sdata_d = sh_l_q[15];
            sh_l_d  = {sh_l_q[14:0], 1'b0};
         end else if (slot_d >= RightFirst && slot_d <= RightLast) begin
            sdata_d = sh_r_q[15];
            sh_r_d  = {sh_r_q[14:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         div_q       <= '0;
         bclk_q      <= 1'b0;
         slot_q      <= SlotLast;
         lrclk_q     <= 1'b1;
         sdata_q     <= 1'b0;
         sh_l_q      <= '0;
         sh_r_q      <= '0;
         underflow_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         div_q       <= div_d;
         bclk_q      <= bclk_d;
         slot_q      <= slot_d;
         lrclk_q     <= lrclk_d;
         sdata_q     <= sdata_d;
         sh_l_q      <= sh_l_d;
         sh_r_q      <= sh_r_d;
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
      end
   end

   assign sample_ready    = !fifo_full;
   assign i2s_bclk        = bclk_q;
   assign i2s_lrclk       = lrclk_q;
   assign i2s_sdata       = sdata_q;
   assign underflow_count = underflow_q;
   assign overflow        = overflow_q;

endmodule

// File: tb/tb_dac_i2s_serializer.sv
// Self-checking bench: every clock is compared against a cycle-count based I2S frame model.
module tb_dac_i2s_serializer;

   localparam int unsigned D  = 2;
   localparam int unsigned FD = 4;

   logic               clock = 1'b0;
   logic               reset;
   logic signed [15:0] sample_l, sample_r;
   logic               sample_valid;
   logic               sample_ready;
   logic [2:0]         fifo_level;
   logic               i2s_bclk, i2s_lrclk, i2s_sdata;
   logic [7:0]         underflow_count;
   logic               overflow;

   int vectors = 0;
   int miscompares = 0;

   // Model state: clocks since reset, queued pairs, pair currently on the wire.
   int          n = 0;
   logic [31:0] q[$];
   logic [31:0] cur = '0;
   int          und = 0;
   logic        ovf = 1'b0;
   int          und_before;

   dac_i2s_serializer #(
      .BCLK_DIV   (D),
      .FIFO_DEPTH (FD)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .sample_l        (sample_l),
      .sample_r        (sample_r),
      .sample_valid    (sample_valid),
      .sample_ready    (sample_ready),
      .fifo_level      (fifo_level),
      .i2s_bclk        (i2s_bclk),
      .i2s_lrclk       (i2s_lrclk),
      .i2s_sdata       (i2s_sdata),
      .underflow_count (underflow_count),
      .overflow        (overflow)
   );

   always #5 clock = ~clock;

   function automatic int slot_at(int m);
      return (63 + m / (2 * D)) % 64;
   endfunction

   function automatic bit is_load(int m);
      return (m > 0) && (m % (2 * D) == 0) && ((m / (2 * D)) % 64 == 1);
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s at n=%0d: observed %0h expected %0h", tag, n, obs, exp);
      end
   endtask

   task automatic step();
      int   pre;
      int   s;
      logic exp_sd;
      @(posedge clock);
      if (!reset) begin
         n = 0; q.delete(); cur = '0; und = 0; ovf = 1'b0;
      end else begin
         pre = q.size();
         n++;
         if (is_load(n)) begin
            if (pre > 0) cur = q.pop_front();
            else begin
               cur = '0;
               if (und < 255) und++;
            end
         end
         if (sample_valid) begin
            if (pre < FD) q.push_back({sample_l, sample_r});
            else ovf = 1'b1;
         end
      end
      #1;
      s = slot_at(n);
      exp_sd = 1'b0;
      if (s >= 1 && s <= 16) exp_sd = cur[16 + 16 - s];
      else if (s >= 33 && s <= 48) exp_sd = cur[48 - s];
      check("bclk", 32'(i2s_bclk), 32'((n / D) % 2));
      check("lrclk", 32'(i2s_lrclk), 32'(s >= 32));
      check("sdata", 32'(i2s_sdata), 32'(exp_sd));
      check("level", 32'(fifo_level), 32'(q.size()));
      check("ready", 32'(sample_ready), 32'(q.size() < FD));
      check("underflow", 32'(underflow_count), 32'(und));
      check("overflow", 32'(overflow), 32'(ovf));
   endtask

   task automatic wait_slot(int target);
      int guard = 0;
      while (slot_at(n) != target && guard < 2 * D * 64 + 4) begin
         step();
         guard++;
      end
      check("wait_slot_timeout", 32'(slot_at(n)), 32'(target));
   endtask

   task automatic push(logic [15:0] l, logic [15:0] r);
      sample_l = l; sample_r = r; sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
      repeat (3) step();
      reset = 1'b1;

      // Idle: zeros on the wire, one underflow per frame.
      repeat (600) step();
      check("idle_underflows", 32'(underflow_count), 32'd3);

      // Single known pair.
      wait_slot(5);
      push(16'h8001, 16'h7FFE);
      check("single_level", 32'(fifo_level), 32'd1);
      repeat (2 * 2 * D * 64) step();
      check("single_drained", 32'(fifo_level), 32'd0);

      // Five back-to-back random pairs into a depth-4 FIFO.
      wait_slot(5);
      for (int i = 0; i < 5; i++) push(16'($urandom), 16'($urandom));
      check("ovf_ready", 32'(sample_ready), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_level", 32'(fifo_level), 32'd4);
      repeat (5 * 2 * D * 64) step();

      // Push exactly on the load clock with an empty FIFO.
      begin
         int guard = 0;
         while (!is_load(n + 1) && guard < 2 * D * 64 + 4) begin
            step();
            guard++;
         end
         check("load_align_timeout", 32'(is_load(n + 1)), 32'd1);
      end
      und_before = und;
      push(16'h1234, 16'hABCD);
      check("edge_underflow", 32'(underflow_count), 32'(und_before + 1));
      check("edge_level", 32'(fifo_level), 32'd1);
      repeat (2 * 2 * D * 64) step();

      // Random sparse traffic.
      for (int i = 0; i < 1024; i++) begin
         sample_l = 16'($urandom); sample_r = 16'($urandom);
         sample_valid = ($urandom_range(0, 47) == 0);
         step();
      end
      sample_valid = 1'b0;

      // Idle until the underflow counter saturates, then a few more frames.
      begin
         int guard = 0;
         while (und < 255 && guard < 300 * 2 * D * 64) begin
            step();
            guard++;
         end
      end
      repeat (3 * 2 * D * 64) step();
      check("underflow_sat", 32'(underflow_count), 32'd255);

      // Reset mid-frame with three pairs queued.
      wait_slot(1);
      for (int i = 0; i < 3; i++) push(16'($urandom), 16'($urandom));
      wait_slot(20);
      check("pre_reset_level", 32'(fifo_level), 32'd3);
      reset = 1'b0;
      step();
      check("rst_bclk", 32'(i2s_bclk), 32'd0);
      check("rst_lrclk", 32'(i2s_lrclk), 32'd1);
      check("rst_sdata", 32'(i2s_sdata), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_ready", 32'(sample_ready), 32'd1);
      check("rst_underflow", 32'(underflow_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      reset = 1'b1;
      repeat (600) step();
      check("restart_underflows", 32'(underflow_count), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dac_i2s_serializer.md
# dac_i2s_serializer

Output stage directly downstream of the DSP. Accepts signed 16-bit stereo samples (the DSP's `dac_out_l`/`dac_out_r`) through a valid/ready handshake, buffers them in a small FIFO, and serializes them as a standard Philips I2S stream (BCLK, LRCLK, SDATA) for an external audio DAC. Underflow and overflow are tracked so the board-level bench can detect rate mismatch between the DSP and the DAC clock.

## Interface
Parameters:
- `BCLK_DIV`, default 4: system clocks per BCLK half-period. BCLK = f_clock/(2·BCLK_DIV); sample rate = f_clock/(128·BCLK_DIV). Must be ≥ 1.
- `FIFO_DEPTH`, default 4: stereo entries. Power of two, ≥ 2.

Ports:
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `sample_l`  in  16  signed left sample.
- `sample_r`  in  16  signed right sample.
- `sample_valid`  in  1  a sample pair is presented this cycle.
- `sample_ready`  out  1  FIFO not full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  entries currently stored.
- `i2s_bclk`  out  1  bit clock.
- `i2s_lrclk`  out  1  word select: 0 = left, 1 = right.
- `i2s_sdata`  out  1  serial data, MSB first.
- `underflow_count`  out  8  frames sent with an empty FIFO; saturates at 255.
- `overflow`  out  1  sticky; set when `sample_valid` is high while `sample_ready` is low.

## Operation
- Push: `sample_valid && sample_ready` writes {l, r} to the FIFO tail. `sample_valid` with `!sample_ready` drops the pair and sets `overflow`.
- `sample_ready = !full`, taken from registered state. A pop in the same cycle does not make room for a push.
- A frame is 64 slots (BCLK periods), counted by `slot`, 0..63. Slots 0–31: `i2s_lrclk`=0. Slots 32–63: `i2s_lrclk`=1.
- Frame load happens on the clock where `slot` advances 63→0:
  - If not empty, pop one entry into the left and right shift registers.
  - If empty, load zeros into both and increment `underflow_count` (saturating).
- Left bit 15 is driven in slot 1 and bit 0 in slot 16. Slots 17–31 and slot 0 drive 0. Right channel is the same pattern offset by 32 (MSB in slot 33). This is the I2S one-BCLK delay.
- Push and pop in the same cycle on a non-empty, non-full FIFO: level unchanged. A push into an empty FIFO on the same cycle as a load is not bypassed: the frame underflows and the sample is kept for the next frame.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Divider counts 0..BCLK_DIV−1. At terminal count it toggles `i2s_bclk` and wraps.
- On a falling BCLK toggle (1→0), in the same clock: `slot` advances, and `i2s_lrclk`/`i2s_sdata` update. The DAC therefore samples stable data on the rising edge.
- Reset values: `i2s_bclk`=0, `i2s_lrclk`=1, `i2s_sdata`=0, `slot`=63, divider=0, FIFO empty, `fifo_level`=0, `sample_ready`=1, `underflow_count`=0, `overflow`=0.
- After reset deasserts, first BCLK rise at clock BCLK_DIV. First falling edge at clock 2·BCLK_DIV enters slot 0 and performs the first frame load.
- Latency: a pair pushed into an empty FIFO is loaded at the next 63→0 transition. Its left MSB appears one BCLK later.
- Reset asserted mid-frame: all state returns to reset values on that clock. FIFO contents are discarded and the partial frame is abandoned.

## Structure
- Shared package `audio_pkg`: `stereo_sample_t` (packed struct {logic signed [15:0] l, r}), `I2S_SLOTS_PER_FRAME`=64, `I2S_DATA_BITS`=16.
- Sub-module `stereo_sample_fifo`: synchronous FIFO of `stereo_sample_t` with push/pop/full/empty/level. Instantiated once.
- Top level contains the BCLK divider, slot counter, shift registers, and status counters.

## Test plan
- Reset, BCLK_DIV=2, no pushes → BCLK period 4 clocks; LRCLK 0 for 32 BCLKs then 1; SDATA constantly 0; `underflow_count` increments once per 256 clocks.
- Push {l=16'h8001, r=16'h7FFE}, then idle → next frame left slots 1–16 = 1000000000000001, right slots 33–48 = 0111111111111110, all other slots 0; `fifo_level` 1→0 at load.
- Push 5 pairs back-to-back with FIFO_DEPTH=4 → `sample_ready` low after 4th push; 5th pair dropped; `overflow`=1 and stays 1 until reset.
- Push on exactly the load clock with FIFO empty → frame outputs zeros, `underflow_count`+1, `fifo_level`=1, and the pair is sent in the following frame.
- Force 300 empty frames → `underflow_count` holds at 255.
- Assert `reset` at slot 20 with 3 entries queued → next clock all outputs at reset values, `fifo_level`=0; restart timing matches the first scenario.
